// File: rtl/pim_stream_loader.sv
// Streams operands A then B into flat arrays for the PIM controller, pulses start,
// captures the result and drains it row-major; define PIM_LOADER_TIMEOUT_EN for the WAIT timeout.
module pim_stream_loader #(
  parameter int WIDTH          = 16,
  parameter int MATRIX_SIZE    = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] matrix_A [MATRIX_SIZE*MATRIX_SIZE],
  output logic [WIDTH-1:0] matrix_B [MATRIX_SIZE*MATRIX_SIZE],
  output logic             start,
  input  logic [WIDTH-1:0] result   [MATRIX_SIZE*MATRIX_SIZE],
  input  logic             result_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             err
);
  localparam int NN = MATRIX_SIZE * MATRIX_SIZE;
  localparam int CW = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [CW-1:0] LAST = CW'(NN - 1);

  localparam logic [2:0] S_LOAD_A = 3'd0;
  localparam logic [2:0] S_LOAD_B = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;

  if (TIMEOUT_CYCLES < 1 || MATRIX_SIZE < 1) begin : g_bad_params
    $error("pim_stream_loader: TIMEOUT_CYCLES and MATRIX_SIZE must be positive");
  end

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [WIDTH-1:0] a_q   [NN];
  logic [WIDTH-1:0] b_q   [NN];
  logic [WIDTH-1:0] buf_q [NN];
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             err_q, err_d;
  logic             in_xfer, out_xfer, capture, timeout;

  assign in_ready = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid_q && out_ready;
  assign capture  = (state_q == S_WAIT) && result_ready;
  assign cnt_inc  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;

`ifdef PIM_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_q;

  // Counter idles at zero outside WAIT, so it is fresh on every WAIT entry.
  always_ff @(posedge clk) begin
    if (rst || state_q != S_WAIT) wait_q <= '0;
    else                          wait_q <= wait_q + 1'b1;
  end
  assign timeout = (state_q == S_WAIT) && !result_ready && (wait_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    err_d       = err_q;
    case (state_q)
      S_LOAD_A: if (in_xfer) begin
        cnt_d = cnt_inc;
        if (cnt_q == LAST) state_d = S_LOAD_B;
      end
      S_LOAD_B: if (in_xfer) begin
        cnt_d = cnt_inc;
        if (cnt_q == LAST) state_d = S_START;
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (capture) begin
          state_d     = S_DRAIN;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          out_data_d  = result[0];
          out_last_d  = (NN == 1);
        end else if (timeout) begin
          state_d     = S_DRAIN;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          out_data_d  = '0;
          out_last_d  = (NN == 1);
          err_d       = 1'b1;
        end
      end
      S_DRAIN: if (out_xfer) begin
        if (out_last_q) begin
          state_d     = S_LOAD_A;
          cnt_d       = '0;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end else begin
          cnt_d      = cnt_inc;
          out_data_d = buf_q[cnt_inc];
          out_last_d = (cnt_inc == LAST);
        end
      end
      default: state_d = S_LOAD_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LOAD_A;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
      for (int i = 0; i < NN; i++) begin
        a_q[i]   <= '0;
        b_q[i]   <= '0;
        buf_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
      if (in_xfer && state_q == S_LOAD_A) a_q[cnt_q] <= in_data;
      if (in_xfer && state_q == S_LOAD_B) b_q[cnt_q] <= in_data;
      for (int i = 0; i < NN; i++) begin
        if (capture)      buf_q[i] <= result[i];
        else if (timeout) buf_q[i] <= '0;
      end
    end
  end

  assign matrix_A  = a_q;
  assign matrix_B  = b_q;
  assign start     = (state_q == S_START);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = !((state_q == S_LOAD_A) && (cnt_q == '0));
  assign err       = err_q;
endmodule

// File: tb/tb_pim_stream_loader.sv
// Bench for pim_stream_loader: table of transactions plus reset/timeout sequences,
// checked against a plain matrix-product model of the stimulus.
module tb_pim_stream_loader;
  localparam int W = 16, N = 4, NN = 16, TO = 50;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_ready, start, result_ready;
  logic         out_valid, out_ready, out_last, busy, err;
  logic [W-1:0] in_data, out_data;
  logic [W-1:0] matrix_A [NN];
  logic [W-1:0] matrix_B [NN];
  logic [W-1:0] result   [NN];

  pim_stream_loader #(.WIDTH(W), .MATRIX_SIZE(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .matrix_A(matrix_A), .matrix_B(matrix_B), .start(start), .result(result),
    .result_ready(result_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .err(err));

  int checks = 0, failures = 0;
  int start_count = 0, ctl_timer = 0, rr_left = 0, rr_hold = 1;
  bit ctl_en = 1'b1, exp_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural controller: product of the presented operands, 20 cycles after start.
  always @(negedge clk) begin
    if (rst) begin
      ctl_timer = 0; rr_left = 0; result_ready = 1'b0;
      for (int i = 0; i < NN; i++) result[i] = '0;
    end else begin
      if (start) begin
        start_count++;
        if (ctl_en) ctl_timer = 20;
      end else if (ctl_timer > 0) begin
        ctl_timer--;
        if (ctl_timer == 0) begin
          for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
              logic [31:0] acc;
              acc = 0;
              for (int k = 0; k < N; k++) acc += matrix_A[i*N+k] * matrix_B[k*N+j];
              result[i*N+j] = acc[15:0];
            end
          rr_left = rr_hold;
        end
      end
      result_ready = (rr_left > 0);
      if (rr_left > 0) rr_left--;
    end
  end

  function automatic logic [W-1:0] gen(input int kind, input int i);
    case (kind)
      0:       return (i / N == i % N) ? 16'd1 : 16'd0;
      1:       return W'(i + 1);
      2:       return 16'd2;
      3:       return 16'd3;
      default: return W'($urandom);
    endcase
  endfunction

  typedef struct {
    int a_kind; int b_kind; int gap_pct; int omode; int rr_len;
    bit ck; logic [W-1:0] ef; logic [W-1:0] el; int abort_after;
  } vec_t;

  task automatic run_txn(input vec_t v, input bit expect_zero);
    logic [W-1:0] a [NN];
    logic [W-1:0] b [NN];
    logic [W-1:0] c [NN];
    logic [W-1:0] got [$];
    logic [W-1:0] prev_d;
    logic [31:0]  acc;
    int idx, cyc, n, early, ready_bad, stall_bad, last_bad, mism, nz, starts0;
    bit prev_stall, prev_l, r;
    for (int i = 0; i < NN; i++) begin a[i] = gen(v.a_kind, i); b[i] = gen(v.b_kind, i); end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        acc = 0;
        for (int k = 0; k < N; k++) acc += a[i*N+k] * b[k*N+j];
        c[i*N+j] = expect_zero ? '0 : acc[15:0];
      end
    rr_hold = v.rr_len; starts0 = start_count;
    idx = 0; cyc = 0; early = 0; out_ready = 1'b0;
    while (idx < 2*NN && cyc < 5000) begin
      @(negedge clk); cyc++;
      if (start) early++;
      in_valid = ($urandom_range(99) >= v.gap_pct);
      in_data  = (idx < NN) ? a[idx] : b[idx-NN];
      if (in_valid && in_ready) idx++;
    end
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'hDEAD;
    chk("inputs_accepted", idx, 2*NN);
    chk("start_early", early, 0);
    chk("start_after_last_b", start, 1);
    mism = 0;
    for (int i = 0; i < NN; i++) if (matrix_A[i] !== a[i] || matrix_B[i] !== b[i]) mism++;
    chk("operand_arrays", mism, 0);
    cyc = 0; ready_bad = 0;
    do begin
      @(negedge clk); cyc++;
      if (in_ready) ready_bad++;
    end while (!out_valid && cyc < 5000);
    chk("first_out_latency", cyc, ctl_en ? 21 : TO + 1);
    n = 0; cyc = 0; prev_stall = 0; prev_d = '0; prev_l = 0; stall_bad = 0; last_bad = 0;
    while (n < NN && cyc < 5000 && !(v.abort_after >= 0 && n == v.abort_after)) begin
      if (in_ready) ready_bad++;
      r = (v.omode == 0) ? 1'b1 : (v.omode == 1) ? (cyc % 2 == 0) : ($urandom_range(1) == 1);
      out_ready = r;
      if (prev_stall && (!out_valid || out_data !== prev_d || out_last !== prev_l)) stall_bad++;
      if (out_valid && r) begin
        got.push_back(out_data);
        if (out_last !== (n == NN-1)) last_bad++;
        n++; prev_stall = 0;
      end else prev_stall = out_valid;
      prev_d = out_data; prev_l = out_last;
      @(negedge clk); cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("in_ready_low_wait_drain", ready_bad, 0);
    mism = 0;
    for (int k = 0; k < got.size(); k++) if (got[k] !== c[k]) mism++;
    chk("drain_data", mism, 0);
    chk("stall_hold", stall_bad, 0);
    chk("out_last_position", last_bad, 0);
    if (v.abort_after >= 0) begin
      chk("outputs_before_abort", got.size(), v.abort_after);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_in_ready", in_ready, 1);
      chk("abort_busy", busy, 0);
      nz = 0;
      for (int i = 0; i < NN; i++) if (matrix_A[i] !== '0 || matrix_B[i] !== '0) nz++;
      chk("abort_arrays_zero", nz, 0);
      rst = 1'b0; exp_err = 1'b0;
      return;
    end
    chk("drain_count", n, NN);
    if (v.ck) begin
      chk("first_element", got[0], v.ef);
      chk("last_element", got[NN-1], v.el);
    end
    chk("done_out_valid", out_valid, 0);
    chk("done_busy", busy, 0);
    chk("done_in_ready", in_ready, 1);
    chk("start_pulses", start_count - starts0, 1);
    chk("err_flag", err, exp_err);
    nz = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (out_valid || start) nz++; end
    chk("no_second_drain", nz, 0);
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = '{0, 1, 0,  0, 1, 1'b1, 16'd1,  16'd16, -1};
    vecs[1] = '{2, 3, 40, 0, 1, 1'b1, 16'd24, 16'd24, -1};
    vecs[2] = '{0, 1, 0,  1, 1, 1'b1, 16'd1,  16'd16, -1};
    vecs[3] = '{2, 3, 0,  0, 5, 1'b1, 16'd24, 16'd24, -1};
    vecs[4] = '{4, 4, 30, 2, 1, 1'b0, 16'd0,  16'd0,  7};
    vecs[5] = '{1, 0, 20, 2, 2, 1'b1, 16'd1,  16'd16, -1};
    vecs[6] = '{4, 4, 30, 2, 3, 1'b0, 16'd0,  16'd0,  -1};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_start", start, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_matrix_A0", matrix_A[0], 0);
    rst = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 7; t++) run_txn(vecs[t], 1'b0);

`ifdef PIM_LOADER_TIMEOUT_EN
    ctl_en = 1'b0; exp_err = 1'b1;
    run_txn('{0, 1, 0, 0, 1, 1'b1, 16'd0, 16'd0, -1}, 1'b1);
    ctl_en = 1'b1;
    run_txn(vecs[0], 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("err_cleared_by_rst", err, 0);
    rst = 1'b0; exp_err = 1'b0;
    @(negedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
